// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin writeback arbiter for the shared regfile write port (optional forwarding: RF_WB_FWD_EN)
module rf_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*AW-1:0] req_waddr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    input  logic                wb_hold,
    output logic                rf_we,
    output logic [AW-1:0]       rf_waddr,
    output logic [DW-1:0]       rf_wdata,
    input  logic [AW-1:0]       rd_raddr1,
    input  logic [AW-1:0]       rd_raddr2,
    input  logic [DW-1:0]       rf_rdata1,
    input  logic [DW-1:0]       rf_rdata2,
    output logic [DW-1:0]       rd_data1,
    output logic [DW-1:0]       rd_data2
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    rr_ptr;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_any;
    logic [AW-1:0]    sel_waddr;
    logic [DW-1:0]    sel_wdata;
    logic             xfer;

    // Scan requesters starting at rr_ptr and pick the first valid one; nothing is granted while held or in reset.
    always_comb begin
        logic [PW:0] pos;
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        pos     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(N_REQ)) begin
                pos = pos - (PW+1)'(N_REQ);
            end
            if (!gnt_any && !wb_hold && rst_n && req_valid[pos[PW-1:0]]) begin
                gnt_any                = 1'b1;
                gnt_idx                = pos[PW-1:0];
                grant[pos[PW-1:0]]     = 1'b1;
            end
        end
    end

    // Route the granted requester's address and data towards the output register.
    always_comb begin
        sel_waddr = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_waddr = req_waddr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);

    // Pointer moves just past the requester that transferred, so every valid requester is served within N_REQ cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    // Registered regfile write; writes to x0 are consumed but never raise rf_we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (xfer) begin
            rf_we    <= (sel_waddr != '0);
            rf_waddr <= sel_waddr;
            rf_wdata <= sel_wdata;
        end else begin
            rf_we    <= 1'b0;
        end
    end

`ifdef RF_WB_FWD_EN
    // Bypass the in-flight write so consumers see it in the same cycle it is presented to the regfile.
    always_comb begin
        rd_data1 = rf_rdata1;
        rd_data2 = rf_rdata2;
        if (rf_we && (rf_waddr == rd_raddr1) && (rd_raddr1 != '0)) begin
            rd_data1 = rf_wdata;
        end
        if (rf_we && (rf_waddr == rd_raddr2) && (rd_raddr2 != '0)) begin
            rd_data2 = rf_wdata;
        end
    end
`else
    // Read data passes straight through; a new value is visible once the regfile has been written.
    always_comb begin
        rd_data1 = rf_rdata1;
        rd_data2 = rf_rdata2;
    end

    logic unused_raddr;
    assign unused_raddr = ^{rd_raddr1, rd_raddr2};
`endif

endmodule
